// File: rtl/bp_be_pkg.sv
// rtl/bp_be_pkg.sv - shared types for the BE FE-command issuer
package bp_be_pkg;

    typedef enum logic [1:0] {
        e_bp_default_cfg,
        e_bp_unicore_cfg,
        e_bp_multicore_cfg
    } bp_params_e;

    localparam int bp_fe_cmd_width_gp = 64;

    // Every supported configuration currently shares the same FE command format.
    function automatic int bp_fe_cmd_width(input bp_params_e cfg);
        case (cfg)
            e_bp_unicore_cfg:   return bp_fe_cmd_width_gp;
            e_bp_multicore_cfg: return bp_fe_cmd_width_gp;
            default:            return bp_fe_cmd_width_gp;
        endcase
    endfunction

    typedef enum logic {
        e_run,
        e_fence
    } bp_be_cmd_issue_state_e;

    typedef struct packed {
        logic                          solo;
        logic [bp_fe_cmd_width_gp-1:0] cmd;
    } bp_be_stage_entry_s;

endpackage

// File: rtl/bp_be_cmd_issue_buf.sv
// rtl/bp_be_cmd_issue_buf.sv - circular staging buffer, 1 write port, 2 read ports
module bp_be_cmd_issue_buf
    import bp_be_pkg::*;
#(
    parameter int  els_p      = 4,
    localparam int ptr_w_lp   = $clog2(els_p),
    localparam int count_w_lp = $clog2(els_p + 1)
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    input  logic                          w_v_i,
    input  bp_be_stage_entry_s            w_entry_i,
    input  logic [1:0]                    deq_i,
    input  logic                          flush_i,
    output bp_be_stage_entry_s            r0_entry_o,
    output logic [bp_fe_cmd_width_gp-1:0] r1_cmd_o,
    output logic [count_w_lp-1:0]         count_o,
    output logic [count_w_lp-1:0]         count_n_o,
    output logic                          nxt_solo0_o,
    output logic                          nxt_solo1_o
);

    bp_be_stage_entry_s    mem_q [els_p];
    logic [ptr_w_lp-1:0]   rptr_q, wptr_q;
    logic [ptr_w_lp-1:0]   rptr1, rptr_n, rptr1_n, wptr_n;
    logic [count_w_lp-1:0] count_q, count_n;

    assign rptr1   = rptr_q + ptr_w_lp'(1);
    assign rptr_n  = flush_i ? wptr_q : rptr_q + ptr_w_lp'(deq_i);
    assign rptr1_n = rptr_n + ptr_w_lp'(1);
    assign wptr_n  = w_v_i ? wptr_q + ptr_w_lp'(1) : wptr_q;

    // A flush drops everything, but a write in the same cycle survives.
    assign count_n = flush_i ? count_w_lp'(w_v_i)
                             : count_q + count_w_lp'(w_v_i) - count_w_lp'(deq_i);

    assign r0_entry_o = mem_q[rptr_q];
    assign r1_cmd_o   = mem_q[rptr1].cmd;
    assign count_o    = count_q;
    assign count_n_o  = count_n;

    // Solo flags of next cycle's head pair, seeing through the in-flight write.
    always_comb begin
        nxt_solo0_o = mem_q[rptr_n].solo;
        nxt_solo1_o = mem_q[rptr1_n].solo;
        if (w_v_i && (wptr_q == rptr_n))  nxt_solo0_o = w_entry_i.solo;
        if (w_v_i && (wptr_q == rptr1_n)) nxt_solo1_o = w_entry_i.solo;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < els_p; i++) mem_q[i] <= '0;
        end else begin
            rptr_q  <= rptr_n;
            wptr_q  <= wptr_n;
            count_q <= count_n;
            if (w_v_i) mem_q[wptr_q] <= w_entry_i;
        end
    end

endmodule

// File: rtl/bp_be_cmd_issuer.sv
// rtl/bp_be_cmd_issuer.sv - dual-lane FE command issuer with solo-command barrier
module bp_be_cmd_issuer
    import bp_be_pkg::*;
#(
    parameter bp_params_e bp_params_p = e_bp_default_cfg,
    parameter int  stage_els_p     = 4,
    localparam int fe_cmd_width_lp = bp_fe_cmd_width(bp_params_p),
    localparam int count_w_lp      = $clog2(stage_els_p + 1)
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic [fe_cmd_width_lp-1:0] cmd_i,
    input  logic                       cmd_solo_i,
    input  logic                       cmd_v_i,
    output logic                       cmd_ready_o,
    output logic [fe_cmd_width_lp-1:0] fe_cmd_o,
    output logic                       fe_cmd_v_o,
    input  logic                       fe_cmd_ready_i,
    output logic [fe_cmd_width_lp-1:0] fe_cmd2_o,
    output logic                       fe_cmd2_v_o,
    input  logic                       fe_cmd2_ready_i,
    input  logic                       fence_done_i,
    input  logic                       flush_i,
    output logic [count_w_lp-1:0]      count_o,
    output logic                       idle_o,
    output logic                       protocol_err_o
);

    bp_be_cmd_issue_state_e state_q, state_n;
    logic fe_cmd_v_q, fe_cmd2_v_q, cmd_ready_q, idle_q, protocol_err_q;
    logic enq, d0, d1, lane_err;
    logic [1:0] deq;
    bp_be_stage_entry_s w_entry, r0_entry;
    logic [count_w_lp-1:0] count_n;
    logic nxt_solo0, nxt_solo1;

    assign enq      = cmd_v_i & cmd_ready_q;
    assign d0       = fe_cmd_v_q & fe_cmd_ready_i;
    assign d1       = fe_cmd2_v_q & fe_cmd2_ready_i & d0;
    assign deq      = {1'b0, d0} + {1'b0, d1};
    assign lane_err = fe_cmd2_v_q & fe_cmd2_ready_i & ~d0;
    assign w_entry  = '{solo: cmd_solo_i, cmd: cmd_i};

    bp_be_cmd_issue_buf #(
        .els_p (stage_els_p)
    ) stage_buf (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .w_v_i       (enq),
        .w_entry_i   (w_entry),
        .deq_i       (deq),
        .flush_i     (flush_i),
        .r0_entry_o  (r0_entry),
        .r1_cmd_o    (fe_cmd2_o),
        .count_o     (count_o),
        .count_n_o   (count_n),
        .nxt_solo0_o (nxt_solo0),
        .nxt_solo1_o (nxt_solo1)
    );

    assign fe_cmd_o = r0_entry.cmd;

    always_comb begin
        state_n = state_q;
        if (flush_i)                                   state_n = e_run;
        else if (state_q == e_run && d0 && r0_entry.solo) state_n = e_fence;
        else if (state_q == e_fence && fence_done_i)   state_n = e_run;
    end

    // Lane valids, ready and idle are precomputed from next-cycle state so they leave flops.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q        <= e_run;
            fe_cmd_v_q     <= 1'b0;
            fe_cmd2_v_q    <= 1'b0;
            cmd_ready_q    <= 1'b1;
            idle_q         <= 1'b1;
            protocol_err_q <= 1'b0;
        end else begin
            state_q        <= state_n;
            fe_cmd_v_q     <= (count_n != '0) && (state_n == e_run);
            fe_cmd2_v_q    <= (count_n >= count_w_lp'(2)) && (state_n == e_run)
                              && !nxt_solo0 && !nxt_solo1;
            cmd_ready_q    <= count_n < count_w_lp'(stage_els_p);
            idle_q         <= (count_n == '0) && (state_n == e_run);
            protocol_err_q <= protocol_err_q | lane_err;
        end
    end

    assign fe_cmd_v_o     = fe_cmd_v_q;
    assign fe_cmd2_v_o    = fe_cmd2_v_q;
    assign cmd_ready_o    = cmd_ready_q;
    assign idle_o         = idle_q;
    assign protocol_err_o = protocol_err_q;

endmodule

// File: tb/tb_bp_be_cmd_issuer.sv
// tb/tb_bp_be_cmd_issuer.sv - self-checking bench for bp_be_cmd_issuer
module tb_bp_be_cmd_issuer;

    localparam int W   = 64;
    localparam int ELS = 4;

    logic         clk_i = 1'b0;
    logic         reset_n_i = 1'b0;
    logic [W-1:0] cmd_i = '0;
    logic         cmd_solo_i = 1'b0, cmd_v_i = 1'b0;
    logic         cmd_ready_o;
    logic [W-1:0] fe_cmd_o, fe_cmd2_o;
    logic         fe_cmd_v_o, fe_cmd2_v_o;
    logic         fe_cmd_ready_i = 1'b0, fe_cmd2_ready_i = 1'b0;
    logic         fence_done_i = 1'b0, flush_i = 1'b0;
    logic [2:0]   count_o;
    logic         idle_o, protocol_err_o;

    int tests_run = 0;
    int tests_failed = 0;

    bp_be_cmd_issuer dut (
        .clk_i           (clk_i),
        .reset_n_i       (reset_n_i),
        .cmd_i           (cmd_i),
        .cmd_solo_i      (cmd_solo_i),
        .cmd_v_i         (cmd_v_i),
        .cmd_ready_o     (cmd_ready_o),
        .fe_cmd_o        (fe_cmd_o),
        .fe_cmd_v_o      (fe_cmd_v_o),
        .fe_cmd_ready_i  (fe_cmd_ready_i),
        .fe_cmd2_o       (fe_cmd2_o),
        .fe_cmd2_v_o     (fe_cmd2_v_o),
        .fe_cmd2_ready_i (fe_cmd2_ready_i),
        .fence_done_i    (fence_done_i),
        .flush_i         (flush_i),
        .count_o         (count_o),
        .idle_o          (idle_o),
        .protocol_err_o  (protocol_err_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: an ordered list of staged commands plus a barrier flag.
    typedef struct {
        logic [W-1:0] cmd;
        bit           solo;
    } ment_t;

    ment_t mq[$];
    bit    m_fence = 1'b0;
    bit    m_err   = 1'b0;

    function automatic bit m_v0();
        return (mq.size() >= 1) && !m_fence;
    endfunction

    function automatic bit m_v1();
        if (mq.size() < 2 || m_fence) return 1'b0;
        return !mq[0].solo && !mq[1].solo;
    endfunction

    function automatic void m_reset();
        mq.delete();
        m_fence = 1'b0;
        m_err   = 1'b0;
    endfunction

    function automatic logic [W-1:0] rand_cmd();
        return {$urandom, $urandom};
    endfunction

    task automatic tick();
        bit v0, v1, d0, d1, enq;
        ment_t e;
        v0  = m_v0();
        v1  = m_v1();
        d0  = v0 && fe_cmd_ready_i;
        d1  = v1 && fe_cmd2_ready_i && d0;
        enq = cmd_v_i && (mq.size() < ELS);
        if (v1 && fe_cmd2_ready_i && !d0) m_err = 1'b1;
        if (flush_i)                             m_fence = 1'b0;
        else if (!m_fence && d0 && mq[0].solo)   m_fence = 1'b1;
        else if (m_fence && fence_done_i)        m_fence = 1'b0;
        if (d0) void'(mq.pop_front());
        if (d1) void'(mq.pop_front());
        if (flush_i) mq.delete();
        if (enq) begin
            e.cmd  = cmd_i;
            e.solo = cmd_solo_i;
            mq.push_back(e);
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        cmd_v_i = 1'b0; cmd_solo_i = 1'b0; cmd_i = '0;
        fe_cmd_ready_i = 1'b0; fe_cmd2_ready_i = 1'b0;
        fence_done_i = 1'b0; flush_i = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_n_i = 1'b0;
        @(posedge clk_i);
        #1;
        reset_n_i = 1'b1;
        m_reset();
    endtask

    task automatic push(input logic [W-1:0] c, input bit solo);
        cmd_i = c; cmd_solo_i = solo; cmd_v_i = 1'b1;
        tick();
        cmd_v_i = 1'b0; cmd_solo_i = 1'b0;
    endtask

    task automatic test_reset();
        reset_n_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
        end
        reset_n_i = 1'b0;
        m_reset();
        for (int i = 0; i < 3; i++) begin
            cmd_i = rand_cmd(); cmd_v_i = $urandom % 2; cmd_solo_i = $urandom % 2;
            fe_cmd_ready_i = $urandom % 2; fe_cmd2_ready_i = $urandom % 2;
            fence_done_i = $urandom % 2; flush_i = $urandom % 2;
            @(posedge clk_i);
            #1;
            tests_run++;
            if ({fe_cmd_v_o, fe_cmd2_v_o, cmd_ready_o, count_o, idle_o, protocol_err_o} !== 8'b00_1_000_1_0) begin
                tests_failed++;
                $display("FAIL reset_outputs cyc=%0d got v0=%b v1=%b rdy=%b cnt=%0d idle=%b err=%b exp v0=0 v1=0 rdy=1 cnt=0 idle=1 err=0",
                         i, fe_cmd_v_o, fe_cmd2_v_o, cmd_ready_o, count_o, idle_o, protocol_err_o);
            end
        end
        idle_inputs();
        reset_n_i = 1'b1;
        tick();
        tests_run++;
        if (idle_o !== 1'b1 || count_o !== 3'd0) begin
            tests_failed++;
            $display("FAIL reset_release got idle=%b cnt=%0d exp idle=1 cnt=0", idle_o, count_o);
        end
    endtask

    task automatic test_pairing();
        logic [W-1:0] a, b, c;
        do_reset();
        a = rand_cmd(); b = rand_cmd(); c = rand_cmd();
        push(a, 1'b0); push(b, 1'b0); push(c, 1'b0);
        fe_cmd_ready_i = 1'b1; fe_cmd2_ready_i = 1'b1;
        tests_run++;
        if (fe_cmd_v_o !== 1'b1 || fe_cmd_o !== a || fe_cmd2_v_o !== 1'b1 || fe_cmd2_o !== b || count_o !== 3'd3) begin
            tests_failed++;
            $display("FAIL pair_first got v0=%b v1=%b cnt=%0d l0=%h l1=%h exp v0=1 v1=1 cnt=3 l0=%h l1=%h",
                     fe_cmd_v_o, fe_cmd2_v_o, count_o, fe_cmd_o, fe_cmd2_o, a, b);
        end
        tick();
        tests_run++;
        if (fe_cmd_v_o !== 1'b1 || fe_cmd_o !== c || fe_cmd2_v_o !== 1'b0 || count_o !== 3'd1) begin
            tests_failed++;
            $display("FAIL pair_second got v0=%b v1=%b cnt=%0d l0=%h exp v0=1 v1=0 cnt=1 l0=%h",
                     fe_cmd_v_o, fe_cmd2_v_o, count_o, fe_cmd_o, c);
        end
        tick();
        tests_run++;
        if (count_o !== 3'd0 || fe_cmd_v_o !== 1'b0 || idle_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL pair_drain got cnt=%0d v0=%b idle=%b exp cnt=0 v0=0 idle=1", count_o, fe_cmd_v_o, idle_o);
        end
    endtask

    task automatic test_barrier();
        logic [W-1:0] a, f, b;
        do_reset();
        a = rand_cmd(); f = rand_cmd(); b = rand_cmd();
        fe_cmd_ready_i = 1'b1; fe_cmd2_ready_i = 1'b1;
        push(a, 1'b0);
        tests_run++;
        if (fe_cmd_v_o !== 1'b1 || fe_cmd_o !== a || fe_cmd2_v_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL barrier_a got v0=%b v1=%b l0=%h exp v0=1 v1=0 l0=%h", fe_cmd_v_o, fe_cmd2_v_o, fe_cmd_o, a);
        end
        push(f, 1'b1);
        tests_run++;
        if (fe_cmd_v_o !== 1'b1 || fe_cmd_o !== f || fe_cmd2_v_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL barrier_f got v0=%b v1=%b l0=%h exp v0=1 v1=0 l0=%h", fe_cmd_v_o, fe_cmd2_v_o, fe_cmd_o, f);
        end
        push(b, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if (fe_cmd_v_o !== 1'b0 || fe_cmd2_v_o !== 1'b0 || count_o !== 3'd1 || idle_o !== 1'b0) begin
                tests_failed++;
                $display("FAIL barrier_hold cyc=%0d got v0=%b v1=%b cnt=%0d idle=%b exp v0=0 v1=0 cnt=1 idle=0",
                         i, fe_cmd_v_o, fe_cmd2_v_o, count_o, idle_o);
            end
            tick();
        end
        fence_done_i = 1'b1;
        tick();
        fence_done_i = 1'b0;
        tests_run++;
        if (fe_cmd_v_o !== 1'b1 || fe_cmd_o !== b) begin
            tests_failed++;
            $display("FAIL barrier_release got v0=%b l0=%h exp v0=1 l0=%h", fe_cmd_v_o, fe_cmd_o, b);
        end
        tick();
        tests_run++;
        if (count_o !== 3'd0 || idle_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL barrier_drain got cnt=%0d idle=%b exp cnt=0 idle=1", count_o, idle_o);
        end
    endtask

    task automatic test_full();
        logic [W-1:0] p[ELS];
        logic [W-1:0] e;
        do_reset();
        for (int i = 0; i < ELS; i++) begin
            p[i] = rand_cmd();
            push(p[i], 1'b0);
        end
        tests_run++;
        if (cmd_ready_o !== 1'b0 || count_o !== 3'd4) begin
            tests_failed++;
            $display("FAIL full_reached got rdy=%b cnt=%0d exp rdy=0 cnt=4", cmd_ready_o, count_o);
        end
        e = rand_cmd();
        cmd_i = e; cmd_v_i = 1'b1;
        tick();
        tests_run++;
        if (cmd_ready_o !== 1'b0 || count_o !== 3'd4) begin
            tests_failed++;
            $display("FAIL full_stall got rdy=%b cnt=%0d exp rdy=0 cnt=4", cmd_ready_o, count_o);
        end
        fe_cmd_ready_i = 1'b1;
        tick();
        fe_cmd_ready_i = 1'b0;
        tests_run++;
        if (cmd_ready_o !== 1'b1 || count_o !== 3'd3) begin
            tests_failed++;
            $display("FAIL full_nobypass got rdy=%b cnt=%0d exp rdy=1 cnt=3", cmd_ready_o, count_o);
        end
        tick();
        cmd_v_i = 1'b0;
        tests_run++;
        if (cmd_ready_o !== 1'b0 || count_o !== 3'd4) begin
            tests_failed++;
            $display("FAIL full_accept got rdy=%b cnt=%0d exp rdy=0 cnt=4", cmd_ready_o, count_o);
        end
        fe_cmd_ready_i = 1'b1; fe_cmd2_ready_i = 1'b1;
        tests_run++;
        if (fe_cmd_o !== p[1] || fe_cmd2_o !== p[2]) begin
            tests_failed++;
            $display("FAIL full_order1 got l0=%h l1=%h exp l0=%h l1=%h", fe_cmd_o, fe_cmd2_o, p[1], p[2]);
        end
        tick();
        tests_run++;
        if (fe_cmd_o !== p[3] || fe_cmd2_o !== e || fe_cmd2_v_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL full_order2 got l0=%h l1=%h v1=%b exp l0=%h l1=%h v1=1", fe_cmd_o, fe_cmd2_o, fe_cmd2_v_o, p[3], e);
        end
        tick();
    endtask

    task automatic test_flush();
        logic [W-1:0] d;
        do_reset();
        for (int i = 0; i < 3; i++) push(rand_cmd(), 1'b0);
        d = rand_cmd();
        flush_i = 1'b1;
        push(d, 1'b0);
        flush_i = 1'b0;
        tests_run++;
        if (count_o !== 3'd1 || fe_cmd_v_o !== 1'b1 || fe_cmd_o !== d) begin
            tests_failed++;
            $display("FAIL flush_run got cnt=%0d v0=%b l0=%h exp cnt=1 v0=1 l0=%h", count_o, fe_cmd_v_o, fe_cmd_o, d);
        end
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        push(rand_cmd(), 1'b1);
        fe_cmd_ready_i = 1'b1;
        push(rand_cmd(), 1'b0);
        push(rand_cmd(), 1'b0);
        fe_cmd_ready_i = 1'b0;
        tests_run++;
        if (fe_cmd_v_o !== 1'b0 || count_o !== 3'd2) begin
            tests_failed++;
            $display("FAIL flush_fenced got v0=%b cnt=%0d exp v0=0 cnt=2", fe_cmd_v_o, count_o);
        end
        d = rand_cmd();
        flush_i = 1'b1;
        push(d, 1'b0);
        flush_i = 1'b0;
        tests_run++;
        if (count_o !== 3'd1 || fe_cmd_v_o !== 1'b1 || fe_cmd_o !== d || idle_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_fence got cnt=%0d v0=%b l0=%h idle=%b exp cnt=1 v0=1 l0=%h idle=0",
                     count_o, fe_cmd_v_o, fe_cmd_o, idle_o, d);
        end
    endtask

    task automatic test_protocol();
        do_reset();
        push(rand_cmd(), 1'b0);
        push(rand_cmd(), 1'b0);
        fe_cmd2_ready_i = 1'b1;
        tick();
        fe_cmd2_ready_i = 1'b0;
        tests_run++;
        if (protocol_err_o !== 1'b1 || count_o !== 3'd2) begin
            tests_failed++;
            $display("FAIL proto_set got err=%b cnt=%0d exp err=1 cnt=2", protocol_err_o, count_o);
        end
        for (int i = 0; i < 3; i++) begin
            cmd_i = rand_cmd(); cmd_v_i = $urandom % 2; fe_cmd_ready_i = $urandom % 2;
            tick();
            tests_run++;
            if (protocol_err_o !== 1'b1) begin
                tests_failed++;
                $display("FAIL proto_sticky cyc=%0d got err=%b exp err=1", i, protocol_err_o);
            end
        end
        do_reset();
        tests_run++;
        if (protocol_err_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL proto_clear got err=%b exp err=0", protocol_err_o);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            cmd_i           = rand_cmd();
            cmd_v_i         = $urandom_range(0, 9) < 7;
            cmd_solo_i      = $urandom_range(0, 9) == 0;
            fe_cmd_ready_i  = $urandom_range(0, 9) < 6;
            fe_cmd2_ready_i = fe_cmd_ready_i ? ($urandom % 2 == 1) : ($urandom_range(0, 63) == 0);
            fence_done_i    = $urandom_range(0, 7) == 0;
            flush_i         = $urandom_range(0, 39) == 0;
            tick();
            tests_run++;
            if (fe_cmd_v_o !== m_v0() || fe_cmd2_v_o !== m_v1()) begin
                tests_failed++;
                $display("FAIL rand_valid cyc=%0d got v0=%b v1=%b exp v0=%b v1=%b", i, fe_cmd_v_o, fe_cmd2_v_o, m_v0(), m_v1());
            end
            tests_run++;
            if (count_o !== 3'(mq.size()) || cmd_ready_o !== (mq.size() < ELS)) begin
                tests_failed++;
                $display("FAIL rand_count cyc=%0d got cnt=%0d rdy=%b exp cnt=%0d rdy=%b", i, count_o, cmd_ready_o, mq.size(), mq.size() < ELS);
            end
            tests_run++;
            if (idle_o !== (mq.size() == 0 && !m_fence) || protocol_err_o !== m_err) begin
                tests_failed++;
                $display("FAIL rand_status cyc=%0d got idle=%b err=%b exp idle=%b err=%b", i, idle_o, protocol_err_o, mq.size() == 0 && !m_fence, m_err);
            end
            if (m_v0()) begin
                tests_run++;
                if (fe_cmd_o !== mq[0].cmd) begin
                    tests_failed++;
                    $display("FAIL rand_lane0 cyc=%0d got %h exp %h", i, fe_cmd_o, mq[0].cmd);
                end
            end
            if (m_v1()) begin
                tests_run++;
                if (fe_cmd2_o !== mq[1].cmd) begin
                    tests_failed++;
                    $display("FAIL rand_lane1 cyc=%0d got %h exp %h", i, fe_cmd2_o, mq[1].cmd);
                end
            end
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_pairing();
        test_barrier();
        test_full();
        test_flush();
        test_protocol();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/bp_be_cmd_issuer.md
# bp_be_cmd_issuer

The BE-side transmitter of FE commands on the dual-lane FE-command interface. It accepts single FE commands from the director/exception logic into a small in-order staging buffer and drives up to two per cycle onto the command queue's lane 0 / lane 1 inputs. It handles barrier ("solo") commands, such as an icache fence, by issuing them alone on lane 0 and holding all younger commands until the FE reports completion.

## Interface
- bp_params_p, default e_bp_default_cfg: processor config; supplies fe_cmd_width_lp via the core-interface width macros.
- stage_els_p, default 4: staging depth; must be a power of two and at least 2.
- clk_i  in  1  clock
- reset_n_i  in  1  reset; one clock, asynchronous assert, active-low.
- cmd_i  in  fe_cmd_width_lp  command to stage
- cmd_solo_i  in  1  cmd_i is a barrier command
- cmd_v_i  in  1  cmd_i valid
- cmd_ready_o  out  1  staging space available; registered, independent of cmd_v_i
- fe_cmd_o / fe_cmd_v_o  out  fe_cmd_width_lp / 1  lane 0 (older) command and valid
- fe_cmd_ready_i  in  1  lane 0 ready
- fe_cmd2_o / fe_cmd2_v_o  out  fe_cmd_width_lp / 1  lane 1 (younger) command and valid
- fe_cmd2_ready_i  in  1  lane 1 ready
- fence_done_i  in  1  pulse: FE finished the outstanding solo command
- flush_i  in  1  discard all staged commands
- count_o  out  clog2(stage_els_p+1)  staged occupancy
- idle_o  out  1  count_o==0 and state e_run
- protocol_err_o  out  1  sticky lane-order violation

## Operation
- Storage is a circular buffer with rptr, wptr (wrap modulo stage_els_p) and count.
- Enqueue enq = cmd_v_i & cmd_ready_o. cmd_ready_o = (count < stage_els_p). There is no bypass: when full, a same-cycle dequeue does not admit a new command.
- Lane 0 presents entry[rptr]. fe_cmd_v_o = (count≥1) & state==e_run.
- Lane 1 presents entry[rptr+1]. fe_cmd2_v_o = (count≥2) & state==e_run & neither entry[rptr] nor entry[rptr+1] is solo.
- Lane transfers:
  - d0 = fe_cmd_v_o & fe_cmd_ready_i
  - d1 = fe_cmd2_v_o & fe_cmd2_ready_i & d0
  - deq = d0 + d1 (0..2)
  - count_n = count + enq − deq
- Lane-order rule: fe_cmd2_v_o & fe_cmd2_ready_i & ~d0 is a violation. It sets protocol_err_o, which stays set until reset. Lane 1 is not consumed in that case.
- FSM:
  - e_run: if d0 transfers a solo entry, go to e_fence.
  - e_fence: both lane valids are low. Enqueue continues while space remains. fence_done_i returns the FSM to e_run; fence_done_i in e_run is ignored.
- flush_i clears count, sets rptr=wptr and returns the FSM to e_run, all at the edge. Handshakes completed in the flush cycle still count as issued. An enqueue in the flush cycle is retained, so count becomes 1.
- Precedence: flush_i takes priority over fence_done_i.

## Timing
- Reset values: fe_cmd_v_o=0, fe_cmd2_v_o=0, cmd_ready_o=1, count_o=0, idle_o=1, protocol_err_o=0, state e_run, pointers 0. Data outputs are don't-care.
- Latency: a command enqueued at cycle N is visible on lane 0 at N+1 at the earliest.
- Input throughput is 1 command per cycle. Output throughput is 2 per cycle when a backlog exists.
- All valid, ready and count outputs come from flops. There is no combinational path from any input to any output.
- A pulse on fence_done_i at cycle N lets the next command issue at N+1.
- Reset asserted mid-operation clears every queue entry and the FSM immediately. No command is issued during reset.

## Structure
- bp_be_pkg: typedef enum bp_be_cmd_issue_state_e {e_run, e_fence}, and a staged-entry struct holding the command plus the solo bit.
- Sub-module bp_be_cmd_issue_buf: circular storage with 1 write port, 2 read ports (rptr, rptr+1), pointers and count.
- The FSM, lane logic and error logic stay in the top module.

## Test plan
- Reset: hold reset_n_i low for 3 cycles with random inputs. Expect every output at its reset value; after release, idle_o=1 and count_o=0.
- Pairing: push A,B,C with both readies low, then raise both. Next cycle lane 0=A and lane 1=B, and count goes 3→1. Following cycle lane 0=C, lane 1 is invalid, and count goes 1→0.
- Barrier: push A, F(solo), B with readies high.
  - A issues alone on lane 0 (lane 1 is not F).
  - Next cycle F issues alone and the FSM enters e_fence. B is held for 5 cycles.
  - Pulse fence_done_i; B issues on the following cycle.
- Full: stage_els_p=4 with readies low. After 4 pushes cmd_ready_o=0 and the 5th push stalls. One lane-0 transfer raises cmd_ready_o on the next cycle, and the 5th command is then accepted.
- Flush: stage 3 commands, then assert flush_i together with a push of D. Next cycle count_o=1 and lane 0=D. Repeat while in e_fence: the FSM returns to e_run.
- Protocol: with 2 entries, drive fe_cmd2_ready_i=1 and fe_cmd_ready_i=0. Next cycle protocol_err_o=1 and count_o is unchanged. protocol_err_o stays high until reset.
